// File: rtl/pc_pkg.sv
// Shared types for the program-counter stage: FSM states,
// next-PC selection codes and default widths.
package pc_pkg;

   localparam int ADDR_W_PADRAO = 10;
   localparam int OFFS_W_PADRAO = 16;

   typedef enum logic [1:0] {
      EXECUTA,
      ESPERA_ENTRADA,
      PARADO
   } estado_t;

   typedef enum logic [2:0] {
      SEQ,
      BRANCH,
      JUMP,
      JR,
      HOLD
   } sel_pc_t;

endpackage

// File: rtl/unidade_pc_proximo.sv
// Combinational next-PC adder and target mux; all arithmetic
// wraps modulo 2^ADDR_W.
module unidade_pc_proximo
   import pc_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_PADRAO,
   parameter int DATA_W = 32,
   parameter int OFFS_W = OFFS_W_PADRAO
) (
   input  logic [ADDR_W-1:0] pc,
   input  sel_pc_t           sel,
   input  logic [OFFS_W-1:0] offset,
   input  logic [ADDR_W-1:0] endereco_jump,
   input  logic [DATA_W-1:0] registrador_jr,
   output logic [ADDR_W-1:0] proximo
);

   localparam int SW = (OFFS_W > ADDR_W) ? OFFS_W : ADDR_W;
   localparam int RW = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;

   logic [SW-1:0] alvo_branch;
   logic [RW-1:0] alvo_jr;
   logic          unused_bits;

   // Only the low ADDR_W bits of the wide sum matter.
   assign alvo_branch = SW'(pc) + SW'(1) + SW'($signed(offset));
   assign alvo_jr     = RW'(registrador_jr);
   assign unused_bits = ^{alvo_branch, alvo_jr};

   always_comb begin
      proximo = pc;
      unique case (sel)
         SEQ:     proximo = pc + ADDR_W'(1);
         BRANCH:  proximo = alvo_branch[ADDR_W-1:0];
         JUMP:    proximo = endereco_jump;
         JR:      proximo = alvo_jr[ADDR_W-1:0];
         HOLD:    proximo = pc;
         default: proximo = pc;
      endcase
   end

endmodule

// File: rtl/unidade_pc.sv
// Program-counter stage with run/wait/halt sequencing.
// Optional redirect counter: PC_CONTADOR_DESVIO_EN.
module unidade_pc
   import pc_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_PADRAO,
   parameter int DATA_W   = 32,
   parameter int OFFS_W   = OFFS_W_PADRAO,
   parameter int RESET_PC = 0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              habilita,
   input  logic              control_branch,
   input  logic              control_jump,
   input  logic              control_jr,
   input  logic              control_halt,
   input  logic              control_in,
   input  logic              entrada_valida,
   input  logic              continuar,
   input  logic [OFFS_W-1:0] offset,
   input  logic [ADDR_W-1:0] endereco_jump,
   input  logic [DATA_W-1:0] registrador_jr,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_link,
   output logic              parado,
   output logic              esperando,
   output logic [31:0]       contador_desvios
);

   estado_t           estado;
   estado_t           estado_prox;
   sel_pc_t           sel;
   logic              desvio;
   logic [ADDR_W-1:0] proximo;

   assign pc_link = pc + ADDR_W'(1);

   unidade_pc_proximo #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .OFFS_W (OFFS_W)
   ) u_proximo (
      .pc             (pc),
      .sel            (sel),
      .offset         (offset),
      .endereco_jump  (endereco_jump),
      .registrador_jr (registrador_jr),
      .proximo        (proximo)
   );

   // Controls overlap, so the EXECUTA decode is a strict priority chain.
   always_comb begin
      sel         = HOLD;
      estado_prox = estado;
      desvio      = 1'b0;
      unique case (estado)
         EXECUTA: begin
            priority case (1'b1)
               control_halt:
                  estado_prox = PARADO;
               (control_in && !entrada_valida):
                  estado_prox = ESPERA_ENTRADA;
               control_jr: begin
                  sel    = JR;
                  desvio = 1'b1;
               end
               control_jump: begin
                  sel    = JUMP;
                  desvio = 1'b1;
               end
               control_branch: begin
                  sel    = BRANCH;
                  desvio = 1'b1;
               end
               default:
                  sel = SEQ;
            endcase
         end
         ESPERA_ENTRADA: begin
            if (entrada_valida) begin
               sel         = SEQ;
               estado_prox = EXECUTA;
            end
         end
         PARADO: begin
            if (continuar) begin
               sel         = SEQ;
               estado_prox = EXECUTA;
            end
         end
         default:
            estado_prox = EXECUTA;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pc        <= ADDR_W'(RESET_PC);
         estado    <= EXECUTA;
         parado    <= 1'b0;
         esperando <= 1'b0;
      end else if (habilita) begin
         pc        <= proximo;
         estado    <= estado_prox;
         parado    <= (estado_prox == PARADO);
         esperando <= (estado_prox == ESPERA_ENTRADA);
      end
   end

`ifdef PC_CONTADOR_DESVIO_EN
   logic [31:0] contador_q;

   always_ff @(posedge clock) begin
      if (reset)
         contador_q <= '0;
      else if (habilita && desvio)
         contador_q <= contador_q + 32'd1;
   end

   assign contador_desvios = contador_q;
`else
   logic unused_desvio;

   assign unused_desvio    = desvio;
   assign contador_desvios = '0;
`endif

endmodule
